// File: rtl/mp3_play_scheduler_if.sv
// Bundle of request/grant and trigger-output signals between the requesting
// FSMs (master side) and mp3_play_scheduler (slave side).
interface mp3_play_scheduler_if #(
  parameter int N_REQ = 4
);
  logic               tick;
  logic [N_REQ-1:0]   req;
  logic [6*N_REQ-1:0] track_flat;
  logic [N_REQ-1:0]   grant;
  logic               reject;
  logic [5:0]         play_number;
  logic               busy;

  modport master (
    output tick, req, track_flat,
    input  grant, reject, play_number, busy
  );

  modport slave (
    input  tick, req, track_flat,
    output grant, reject, play_number, busy
  );
endinterface

// File: rtl/mp3_play_scheduler.sv
// mp3_play_scheduler: shares one MP3 trigger channel among N_REQ requesters.
// A winner is picked from the pending requests, its track code is driven to the
// trigger decoder for PULSE_TICKS tick strobes, then code 0 for GAP_TICKS ticks.
// Illegal tracks (0 or above MAX_TRACK) are granted and rejected without playing.
// Optional feature: define MP3_SCHED_RR_EN for round-robin arbitration; when
// undefined, the lowest requesting index wins (fixed priority).
module mp3_play_scheduler #(
  parameter int N_REQ       = 4,
  parameter int PULSE_TICKS = 3,
  parameter int GAP_TICKS   = 2,
  parameter int MAX_TRACK   = 18
) (
  input  logic                  clock,
  input  logic                  reset,
  mp3_play_scheduler_if.slave   bus
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAX_CNT = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [5:0]         play_q;
  logic [5:0]         play_next;
  logic               busy_q;
  logic               busy_next;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   grant_next;
  logic               reject_q;
  logic               reject_next;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [5:0]         win_track;
  logic               win_legal;
  logic               arb_en;

`ifdef MP3_SCHED_RR_EN
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_next;

  // Round-robin search: first pending request at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[(int'(rr_ptr) + i) % N_REQ]) begin
        found = 1'b1;
        win   = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  // Pointer moves past the last winner, whether its track played or was rejected.
  always_comb begin
    rr_next = rr_ptr;
    if (arb_en) begin
      if (win == IDX_W'(N_REQ - 1)) begin
        rr_next = '0;
      end else begin
        rr_next = win + IDX_W'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_next;
    end
  end
`else
  // Fixed priority search: lowest pending index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end
`endif

  // Winner's track code and its legality; track_flat only matters in the grant cycle.
  always_comb begin
    win_track = bus.track_flat[int'(win) * 6 +: 6];
    win_legal = (win_track != 6'd0) && (int'(win_track) <= MAX_TRACK);
  end

  // Arbitrate only in IDLE and never while the previous grant is still visible,
  // so a requester gets one cycle to drop req before it could be picked again.
  always_comb begin
    arb_en = (state == IDLE) && (grant_q == '0) && found;
  end

  // Next-state and next-output logic; ticks only advance the counter in PULSE/GAP.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    play_next   = play_q;
    busy_next   = busy_q;
    grant_next  = '0;
    reject_next = 1'b0;
    case (state)
      IDLE: begin
        if (arb_en) begin
          grant_next = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          if (win_legal) begin
            play_next  = win_track;
            busy_next  = 1'b1;
            cnt_next   = CNT_W'(PULSE_TICKS);
            state_next = PULSE;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      PULSE: begin
        if (bus.tick) begin
          if (cnt == CNT_W'(1)) begin
            play_next  = 6'd0;
            cnt_next   = CNT_W'(GAP_TICKS);
            state_next = GAP;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (bus.tick) begin
          if (cnt == CNT_W'(1)) begin
            busy_next  = 1'b0;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        play_next  = 6'd0;
        busy_next  = 1'b0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset silences the decoder at once, even mid-pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      play_q   <= 6'd0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      play_q   <= play_next;
      busy_q   <= busy_next;
      grant_q  <= grant_next;
      reject_q <= reject_next;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.reject      = reject_q;
  assign bus.play_number = play_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mp3_play_scheduler.sv
// Scoreboard bench for mp3_play_scheduler: stimulus pushes expected events
// (grant/reject, play on, play off with pulse length, busy off with gap length)
// and an independent monitor pops and compares them as the DUT produces them.
module tb_mp3_play_scheduler;

  localparam int N_REQ       = 4;
  localparam int PULSE_TICKS = 3;
  localparam int GAP_TICKS   = 2;
  localparam int MAX_TRACK   = 18;

  logic clock = 1'b0;
  logic reset;

  mp3_play_scheduler_if #(.N_REQ(N_REQ)) bus ();

  mp3_play_scheduler #(
    .N_REQ       (N_REQ),
    .PULSE_TICKS (PULSE_TICKS),
    .GAP_TICKS   (GAP_TICKS),
    .MAX_TRACK   (MAX_TRACK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  typedef enum int {EV_GRANT, EV_PLAY_ON, EV_PLAY_OFF, EV_BUSY_OFF} ev_kind_t;

  typedef struct {
    ev_kind_t         kind;
    logic [N_REQ-1:0] grant;
    logic             reject;
    logic [5:0]       value;
    int               ticks;
    bit               after_busy;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic void check_val(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endfunction

  function automatic void push_grant(logic [N_REQ-1:0] g, logic rej, bit after_busy);
    ev_t e;
    e.kind = EV_GRANT; e.grant = g; e.reject = rej; e.value = 6'd0;
    e.ticks = 0; e.after_busy = after_busy;
    exp_q.push_back(e);
  endfunction

  function automatic void push_simple(ev_kind_t k, logic [5:0] v, int ticks);
    ev_t e;
    e.kind = k; e.grant = '0; e.reject = 1'b0; e.value = v;
    e.ticks = ticks; e.after_busy = 1'b0;
    exp_q.push_back(e);
  endfunction

  // A complete legal play: code on, code off after PULSE_TICKS, busy off after GAP_TICKS.
  function automatic void push_play(logic [5:0] track);
    push_simple(EV_PLAY_ON, track, 0);
    push_simple(EV_PLAY_OFF, 6'd0, PULSE_TICKS);
    push_simple(EV_BUSY_OFF, 6'd0, GAP_TICKS);
  endfunction

  function automatic void observe(ev_kind_t k, logic [N_REQ-1:0] g, logic rej,
                                  logic [5:0] v, int ticks, int since_busy);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_event actual_kind=%0d grant=%b reject=%0d play=%0d required=none",
               int'(k), g, rej, v);
      return;
    end
    e = exp_q.pop_front();
    check_val("event_kind", int'(k), int'(e.kind));
    case (e.kind)
      EV_GRANT: begin
        check_val("grant_vector", int'(g), int'(e.grant));
        check_val("reject", int'(rej), int'(e.reject));
        if (e.after_busy) check_val("grant_after_busy_cycles", since_busy, 1);
      end
      EV_PLAY_ON:  check_val("play_number", int'(v), int'(e.value));
      EV_PLAY_OFF: check_val("pulse_ticks", ticks, e.ticks);
      default:     check_val("gap_ticks", ticks, e.ticks);
    endcase
  endfunction

  // Monitor: samples DUT outputs on the falling edge and turns changes into events.
  initial begin
    int         cyc = 0;
    int         busy_fall_cyc = -1000;
    int         pulse_ticks = 0;
    int         gap_ticks = 0;
    logic [5:0] last_play = 6'd0;
    logic       last_busy = 1'b0;
    logic       last_tick = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        last_play = 6'd0; last_busy = 1'b0; last_tick = 1'b0;
        pulse_ticks = 0; gap_ticks = 0;
        continue;
      end
      if (last_tick && last_play != 6'd0) pulse_ticks++;
      if (last_tick && last_busy && last_play == 6'd0) gap_ticks++;
      if (bus.grant != '0 || bus.reject)
        observe(EV_GRANT, bus.grant, bus.reject, 6'd0, 0, cyc - busy_fall_cyc);
      if (bus.play_number != last_play) begin
        if (bus.play_number != 6'd0) begin
          observe(EV_PLAY_ON, '0, 1'b0, bus.play_number, 0, 0);
          pulse_ticks = 0;
        end else begin
          observe(EV_PLAY_OFF, '0, 1'b0, 6'd0, pulse_ticks, 0);
          gap_ticks = 0;
        end
      end
      if (last_busy && !bus.busy) begin
        observe(EV_BUSY_OFF, '0, 1'b0, 6'd0, gap_ticks, 0);
        busy_fall_cyc = cyc;
      end
      last_play = bus.play_number;
      last_busy = bus.busy;
      last_tick = bus.tick;
    end
  end

  // Tick strobe: one cycle high every fourth clock.
  initial begin
    int tc = 0;
    bus.tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tc++;
      bus.tick = (tc % 4 == 0);
    end
  end

  // Requester model: each requester drops its req once it sees its grant.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) bus.req = bus.req & ~bus.grant;
    end
  end

  task automatic request(input int idx, input logic [5:0] track);
    @(negedge clock);
    bus.track_flat[idx*6 +: 6] = track;
    bus.req[idx] = 1'b1;
  endtask

  task automatic wait_for_play(input logic [5:0] value, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (bus.play_number == value) seen = 1'b1;
    end
    check_val("wait_play_number_timeout", int'(seen), 1);
  endtask

  task automatic wait_quiet(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !bus.busy && bus.grant == '0) done = 1'b1;
    end
    check_val("events_pending", exp_q.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  // Stimulus: directed scenarios with hand-computed event sequences.
  initial begin
    bit seen;
    reset = 1'b1;
    bus.req = '0;
    bus.track_flat = '0;
    repeat (3) @(negedge clock);
    check_val("reset_play_number", int'(bus.play_number), 0);
    check_val("reset_busy", int'(bus.busy), 0);
    check_val("reset_grant", int'(bus.grant), 0);
    check_val("reset_reject", int'(bus.reject), 0);
    @(posedge clock);
    #2 reset = 1'b0;

    // Collision of req[0]=5 and req[3]=9, with req[0] raised again during the pulse.
    $display("[TB] collision and priority");
    push_grant(4'b0001, 1'b0, 1'b0);
    push_play(6'd5);
`ifdef MP3_SCHED_RR_EN
    push_grant(4'b1000, 1'b0, 1'b1);
    push_play(6'd9);
    push_grant(4'b0001, 1'b0, 1'b0);
    push_play(6'd5);
`else
    push_grant(4'b0001, 1'b0, 1'b1);
    push_play(6'd5);
    push_grant(4'b1000, 1'b0, 1'b0);
    push_play(6'd9);
`endif
    @(negedge clock);
    bus.track_flat[0 +: 6]  = 6'd5;
    bus.track_flat[18 +: 6] = 6'd9;
    bus.req = 4'b1001;
    wait_for_play(6'd5, 40);
    request(0, 6'd5);
    wait_quiet(400);

    // Single request, track 7.
    $display("[TB] single request");
    push_grant(4'b0100, 1'b0, 1'b0);
    push_play(6'd7);
    request(2, 6'd7);
    wait_quiet(200);

    // Illegal tracks 0 and 19 are granted and rejected without playing.
    $display("[TB] illegal tracks");
    push_grant(4'b0010, 1'b1, 1'b0);
    request(1, 6'd0);
    wait_quiet(50);
    check_val("reject0_busy", int'(bus.busy), 0);
    check_val("reject0_play_number", int'(bus.play_number), 0);
    push_grant(4'b0010, 1'b1, 1'b0);
    request(1, 6'd19);
    wait_quiet(50);
    check_val("reject19_busy", int'(bus.busy), 0);
    check_val("reject19_play_number", int'(bus.play_number), 0);

    // Track changed right after grant must not alter the pulse.
    $display("[TB] track change after grant");
    push_grant(4'b0010, 1'b0, 1'b0);
    push_play(6'd3);
    request(1, 6'd3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (bus.grant[1]) seen = 1'b1;
    end
    check_val("wait_grant1_timeout", int'(seen), 1);
    bus.track_flat[6 +: 6] = 6'd4;
    wait_quiet(200);

    // Request raised during GAP is granted one cycle after busy falls.
    $display("[TB] request during gap");
    push_grant(4'b0100, 1'b0, 1'b0);
    push_play(6'd7);
    push_grant(4'b0001, 1'b0, 1'b1);
    push_play(6'd5);
    request(2, 6'd7);
    wait_for_play(6'd7, 40);
    wait_for_play(6'd0, 60);
    check_val("in_gap_busy", int'(bus.busy), 1);
    request(0, 6'd5);
    wait_quiet(400);

    // Reset mid-pulse clears outputs at once; held request is regranted afterwards.
    $display("[TB] reset mid pulse");
    push_grant(4'b0010, 1'b0, 1'b0);
    push_simple(EV_PLAY_ON, 6'd12, 0);
    request(1, 6'd12);
    wait_for_play(6'd12, 40);
    request(1, 6'd12);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check_val("async_reset_play_number", int'(bus.play_number), 0);
    check_val("async_reset_busy", int'(bus.busy), 0);
    check_val("events_before_reset", exp_q.size(), 0);
    push_grant(4'b0010, 1'b0, 1'b0);
    push_play(6'd12);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    wait_quiet(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
